// File: rtl/dac_rnm_pkg.sv
// dac_rnm_pkg: shared FSM state type and code-to-voltage conversion for the RNM DAC.
`default_nettype none

package dac_rnm_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        SETTLING = 1'b1
    } dac_state_e;

    // Ideal transfer function: vref * code / 2**width, in real arithmetic with no rounding.
    function automatic real code_to_volt(input logic [15:0] code, input int width, input real vref);
        return vref * real'(code) / real'(64'd1 << width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dac_rnm.sv
// dac_rnm: real-number-model DAC with valid/ready code input and programmable settle time.
// Optional macro DAC_RNM_SLEW_EN selects a linear ramp instead of a step response while settling.
`default_nettype none

module dac_rnm
    import dac_rnm_pkg::*;
#(
    parameter int  WIDTH         = 8,
    parameter real VREF          = 1.0,
    parameter int  SETTLE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] code_i,
    input  logic             valid_i,
    output logic             ready_o,
    output real              v_o,
    output logic             settled_o,
    output logic [WIDTH-1:0] code_o
);

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);
`ifdef DAC_RNM_SLEW_EN
    localparam real SETTLE_DIV = (SETTLE_CYCLES == 0) ? 1.0 : real'(SETTLE_CYCLES);
`endif

    dac_state_e       state_q, state_d;
    real              v_q, v_d;
    real              start_q, start_d;
    real              target_q, target_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [7:0]       cnt_q, cnt_d;
    real              new_target;

    always_comb begin
        state_d    = state_q;
        v_d        = v_q;
        start_d    = start_q;
        target_d   = target_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        new_target = code_to_volt(16'(code_i), WIDTH, VREF);

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    code_d   = code_i;
                    target_d = new_target;
                    start_d  = v_q;
                    cnt_d    = SETTLE_LD;
                    if (SETTLE_CYCLES == 0) begin
                        v_d = new_target;
                    end else begin
                        state_d = SETTLING;
                    end
                end
            end
            SETTLING: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    // Final edge lands on the exact target, never on an accumulated sum.
                    v_d     = target_q;
                    state_d = IDLE;
                end else begin
`ifdef DAC_RNM_SLEW_EN
                    v_d = start_q + real'(SETTLE_LD - cnt_d) * ((target_q - start_q) / SETTLE_DIV);
`else
                    v_d = start_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            v_q      <= 0.0;
            start_q  <= 0.0;
            target_q <= 0.0;
            code_q   <= '0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            v_q      <= v_d;
            start_q  <= start_d;
            target_q <= target_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ready_o   = (state_q == IDLE);
    assign settled_o = (state_q == IDLE);
    assign v_o       = v_q;
    assign code_o    = code_q;

endmodule

`default_nettype wire

// File: doc/dac_rnm.md
Name: dac_rnm

Overview:
- Real-number-model DAC: the digital-to-analog counterpart of the team's RNM comparator.
- Accepts a digital code through a valid/ready handshake and drives a real-valued analog output. The output settles after a programmable number of clock cycles.
- Used together with the RNM comparator to close mixed-signal loops, for example as the SAR/threshold reference feeding the comparator's n_i.

Parameters:
- WIDTH, 8, code width in bits (1..16).
- VREF, 1.0 (real), full-scale reference voltage.
- SETTLE_CYCLES, 4, clock edges from code acceptance to final output value (0..255).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- code_i  input  WIDTH  requested code.
- valid_i  input  1  code_i is valid.
- ready_o  output  1  block can accept a code.
- v_o  output  real  analog output voltage.
- settled_o  output  1  v_o equals the target of the last accepted code.
- code_o  output  WIDTH  last accepted code.

Behaviour:
- Transfer function: target = VREF * real(code) / 2.0**WIDTH.
  - Code 0 gives 0.0; full scale is VREF*(2**WIDTH-1)/2**WIDTH.
  - Computed in real arithmetic; no rounding.
- FSM states: IDLE, SETTLING.
  - ready_o = (state==IDLE).
  - settled_o = (state==IDLE).
- Accept occurs at edge k when valid_i && ready_o. At that edge:
  - code is latched into code_o.
  - target is computed.
  - start = current v_o is captured.
  - counter is loaded with SETTLE_CYCLES.
- SETTLE_CYCLES>0:
  - State goes SETTLING at edge k; ready_o and settled_o are low for exactly SETTLE_CYCLES cycles.
  - At edge k+SETTLE_CYCLES: v_o = target and the FSM returns to IDLE.
- SETTLE_CYCLES==0: v_o = target at edge k; the FSM stays IDLE and ready_o stays high. Back-to-back codes update v_o every cycle.
- valid_i while in SETTLING is ignored; code_i need not be held. There is no queueing.
- A code equal to the current code_o still runs the full settle sequence.
- Reset (asynchronous assert, any state, including mid-settle):
  - state=IDLE, v_o=0.0, code_o=0, counter=0.
  - ready_o=1, settled_o=1.
  - Any in-flight update is discarded.
- Deassertion is synchronised externally; the first accept is possible at the first edge after rst_ni rises.

Optional Feature:
- Macro: DAC_RNM_SLEW_EN.
- Defined: the output ramps linearly.
  - step = (target-start)/SETTLE_CYCLES.
  - At edge k+i (1<=i<SETTLE_CYCLES), v_o = start + i*step.
  - At edge k+SETTLE_CYCLES, v_o = target exactly, with no accumulated error.
  - SETTLE_CYCLES==0 behaves as the undefined case.
- Undefined: step response. v_o holds start throughout SETTLING and jumps to target at edge k+SETTLE_CYCLES.
- Handshake timing is identical in both builds.

Decomposition:
- Package dac_rnm_pkg holds:
  - state enum dac_state_e {IDLE, SETTLING}.
  - Pure function code_to_volt(code, width, vref) returning real.
- Single module; no sub-module is warranted. The settle counter is inline.

Test Plan:
- Default params, reset, code_i=128, valid_i=1 for one cycle -> ready_o low 4 cycles; v_o=0.0 until edge k+4, then 0.5; code_o=128; settled_o=1.
- With DAC_RNM_SLEW_EN, 0->128 -> v_o = 0.125, 0.25, 0.375, 0.5 at edges k+1..k+4. Then 128->64 -> 0.4375, 0.375, 0.3125, 0.25.
- code_i=255 accepted, then valid_i=1 with code_i=10 during SETTLING -> second code ignored; v_o ends at 0.99609375; code_o=255.
- rst_ni pulled low at edge k+2 of a 0->200 settle -> immediately v_o=0.0, ready_o=1, code_o=0. After release, code 64 -> 0.25 after 4 cycles.
- SETTLE_CYCLES=0, codes 1,2,3 on consecutive cycles with valid_i=1 -> ready_o stays 1; v_o = 0.00390625, 0.0078125, 0.01171875 on consecutive edges.
- Loop check: v_o drives the RNM comparator's n_i with p_i=0.3, codes 76 then 77 -> comparator output 1.0 (0.296875) then 0.0 (0.30078125), sampled after settled_o.
